// File: rtl/rename_regfile.sv
// rename_regfile: architectural register file with per-register rename tags (ROB ids).
//
// Serves NRP parallel, zero-latency operand lookups. When a register has an
// outstanding producer, the read port reports ready=0 and the producer's ROB id
// instead of a value. Dispatch records a rename. Commit writes the value, and it
// clears the rename only if the tag still matches. Flush drops every rename.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   rdy           global enable; state is frozen when low
//   disp_*        dispatch rename request (valid, destination index, ROB id)
//   rp_addr       NRP packed read addresses, port i at [i*AW +: AW]
//   rp_ready      per-port ready flag
//   rp_value      per-port value (0 when not ready)
//   rp_rob_id     per-port pending producer id (0 when ready)
//   cmt_*         ROB commit (valid, destination index, ROB id, value)
//   flush         clear all rename state
//   busy_cnt      number of registers currently renamed
//
// Configuration macro: RENAME_REGFILE_BYPASS_EN. When it is defined, a read of a
// register whose producer commits in the current cycle returns the committed value
// in that same cycle.

module rename_regfile #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned NREG  = 32,
   parameter int unsigned ROB_W = 4,
   parameter int unsigned NRP   = 2,
   localparam int unsigned AW   = $clog2(NREG)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rdy,
   input  logic                  disp_valid,
   input  logic [AW-1:0]         disp_rd,
   input  logic [ROB_W-1:0]      disp_rob_id,
   input  logic [NRP*AW-1:0]     rp_addr,
   output logic [NRP-1:0]        rp_ready,
   output logic [NRP*XLEN-1:0]   rp_value,
   output logic [NRP*ROB_W-1:0]  rp_rob_id,
   input  logic                  cmt_valid,
   input  logic [AW-1:0]         cmt_rd,
   input  logic [ROB_W-1:0]      cmt_rob_id,
   input  logic [XLEN-1:0]       cmt_value,
   input  logic                  flush,
   output logic [AW:0]           busy_cnt
);

   localparam logic [AW:0] CntOne = 1;

   logic [XLEN-1:0]  value_q [NREG];
   logic [ROB_W-1:0] tag_q   [NREG];
   logic [NREG-1:0]  busy_q;
   logic [AW:0]      busy_cnt_q, busy_cnt_d;

   logic disp_en, cmt_en, cmt_clr, flush_en;

   // Register 0 is hardwired: it never gets renamed or written.
   assign disp_en  = rdy && disp_valid && (disp_rd != '0);
   assign cmt_en   = rdy && cmt_valid && (cmt_rd != '0);
   assign flush_en = rdy && flush;
   // Only the youngest rename is retired; a newer tag survives an older commit.
   assign cmt_clr  = cmt_en && busy_q[cmt_rd] && (tag_q[cmt_rd] == cmt_rob_id);

   // Count tracks the post-update number of busy registers. A tag-matching commit
   // to the register being re-renamed this cycle leaves it busy, so it is not a
   // decrement.
   always_comb begin
      busy_cnt_d = busy_cnt_q;
      if (flush_en) begin
         busy_cnt_d = '0;
      end else begin
         if (disp_en && !busy_q[disp_rd]) begin
            busy_cnt_d = busy_cnt_d + CntOne;
         end
         if (cmt_clr && !(disp_en && (disp_rd == cmt_rd))) begin
            busy_cnt_d = busy_cnt_d - CntOne;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q     <= '0;
         busy_cnt_q <= '0;
         for (int unsigned i = 0; i < NREG; i++) begin
            value_q[i] <= '0;
            tag_q[i]   <= '0;
         end
      end else begin
         if (cmt_en) begin
            value_q[cmt_rd] <= cmt_value;
            if (cmt_clr) begin
               busy_q[cmt_rd] <= 1'b0;
            end
         end
         // Later assignments win: flush beats everything, dispatch beats commit.
         if (flush_en) begin
            busy_q <= '0;
         end else if (disp_en) begin
            busy_q[disp_rd] <= 1'b1;
            tag_q[disp_rd]  <= disp_rob_id;
         end
         busy_cnt_q <= busy_cnt_d;
      end
   end

   assign busy_cnt = busy_cnt_q;

   // Read ports look at current state only; same-cycle dispatch is invisible.
   always_comb begin
      logic [AW-1:0] a;
      a         = '0;
      rp_ready  = '0;
      rp_value  = '0;
      rp_rob_id = '0;
      for (int unsigned p = 0; p < NRP; p++) begin
         a = rp_addr[p*AW +: AW];
         if (!busy_q[a]) begin
            rp_ready[p]               = 1'b1;
            rp_value[p*XLEN +: XLEN]  = value_q[a];
`ifdef RENAME_REGFILE_BYPASS_EN
         end else if (cmt_en && (cmt_rd == a) && (tag_q[a] == cmt_rob_id)) begin
            rp_ready[p]               = 1'b1;
            rp_value[p*XLEN +: XLEN]  = cmt_value;
`endif
         end else begin
            rp_rob_id[p*ROB_W +: ROB_W] = tag_q[a];
         end
      end
   end

endmodule
